// File: rtl/acc_order_ctrl.sv
// rtl/acc_order_ctrl.sv - access-order controller gating channel FIFO EMPTY flags
// ACC_ORDER_ERR_EN enables the sticky overflow/misorder flags on ORDER_ERR.
module acc_order_ctrl #(
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int MODE  = 1
) (
    input  logic                       S_CLK,
    input  logic                       S_RESET_N,
    input  logic [NCH-1:0]             WREN,
    input  logic [NCH-1:0]             RDEN,
    input  logic [NCH-1:0]             FIFO_EMPTY_IN,
    output logic [NCH-1:0]             EMPTY_OUT,
    output logic                       ORDER_FULL,
    output logic [$clog2(DEPTH+1)-1:0] ORDER_CNT,
    output logic [1:0]                 ORDER_ERR
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          full_q, full_d;
    logic [1:0]    err_q, err_d;

    logic [IW-1:0] head;
    logic          head_vld;
    logic          pop;
    logic [NCH-1:0] sel_mask;
`ifdef ACC_ORDER_ERR_EN
    logic          overflow;
    logic          misorder;
`endif

    always_comb begin
        head     = mem_q[rd_ptr_q];
        head_vld = (cnt_q != '0);

        // The one channel whose EMPTY is allowed through: queue head or RR grant.
        sel_mask = '0;
        if (MODE == 1) begin
            if (head_vld) sel_mask[head] = 1'b1;
        end else if (MODE == 2) begin
            sel_mask[grant_q] = 1'b1;
        end
        EMPTY_OUT = (MODE == 0) ? FIFO_EMPTY_IN : (~sel_mask | FIFO_EMPTY_IN);

        pop      = (MODE == 1) && head_vld && RDEN[head];
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q - CW'(pop);
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
`ifdef ACC_ORDER_ERR_EN
        overflow = 1'b0;
        misorder = (MODE != 0) && (|(RDEN & ~sel_mask));
`endif

        // Pop is already accounted for in cnt_d, so freed slots are reusable now.
        for (int i = 0; i < NCH; i++) begin
            if ((MODE == 1) && WREN[i]) begin
                if (cnt_d < CW'(DEPTH)) begin
                    mem_d[wr_ptr_d] = IW'(i);
                    wr_ptr_d        = wr_ptr_d + 1'b1;
                    cnt_d           = cnt_d + 1'b1;
                end else begin
`ifdef ACC_ORDER_ERR_EN
                    overflow = 1'b1;
`endif
                end
            end
        end

        full_d = (MODE == 1) && (cnt_d > CW'(DEPTH - NCH));

        grant_d = grant_q;
        if ((MODE == 2) && (RDEN[grant_q] || FIFO_EMPTY_IN[grant_q])) begin
            grant_d = (grant_q == IW'(NCH - 1)) ? '0 : grant_q + 1'b1;
        end

`ifdef ACC_ORDER_ERR_EN
        err_d = err_q | {misorder, overflow};
`else
        err_d = 2'b00;
`endif
    end

    always_ff @(posedge S_CLK or negedge S_RESET_N) begin
        if (!S_RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            full_q   <= 1'b0;
            err_q    <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    // Entry contents are only meaningful below cnt_q, so storage needs no reset.
    always_ff @(posedge S_CLK) begin
        mem_q <= mem_d;
    end

    assign ORDER_FULL = full_q;
    assign ORDER_CNT  = cnt_q;
    assign ORDER_ERR  = err_q;

endmodule

// File: tb/tb_acc_order_ctrl.sv
// tb/tb_acc_order_ctrl.sv - self-checking bench for acc_order_ctrl
// Four instances: A (NCH=2,MODE 1), B (NCH=4,MODE 1), C (NCH=3,MODE 2), D (NCH=2,MODE 0).
`timescale 1ns/1ps
module tb_acc_order_ctrl;

    localparam bit ERR_EN =
`ifdef ACC_ORDER_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [1:0] a_wr, a_rd, a_fe, a_eo, a_err;
    logic       a_full;
    logic [3:0] a_cnt;
    logic [3:0] b_wr, b_rd, b_fe, b_eo;
    logic [1:0] b_err;
    logic       b_full;
    logic [3:0] b_cnt;
    logic [2:0] c_wr, c_rd, c_fe, c_eo;
    logic [1:0] c_err;
    logic       c_full;
    logic [3:0] c_cnt;
    logic [1:0] d_wr, d_rd, d_fe, d_eo, d_err;
    logic       d_full;
    logic [2:0] d_cnt;

    acc_order_ctrl #(.NCH(2), .DEPTH(8), .MODE(1)) u_a (
        .S_CLK(clk), .S_RESET_N(rst_n), .WREN(a_wr), .RDEN(a_rd), .FIFO_EMPTY_IN(a_fe),
        .EMPTY_OUT(a_eo), .ORDER_FULL(a_full), .ORDER_CNT(a_cnt), .ORDER_ERR(a_err));
    acc_order_ctrl #(.NCH(4), .DEPTH(8), .MODE(1)) u_b (
        .S_CLK(clk), .S_RESET_N(rst_n), .WREN(b_wr), .RDEN(b_rd), .FIFO_EMPTY_IN(b_fe),
        .EMPTY_OUT(b_eo), .ORDER_FULL(b_full), .ORDER_CNT(b_cnt), .ORDER_ERR(b_err));
    acc_order_ctrl #(.NCH(3), .DEPTH(8), .MODE(2)) u_c (
        .S_CLK(clk), .S_RESET_N(rst_n), .WREN(c_wr), .RDEN(c_rd), .FIFO_EMPTY_IN(c_fe),
        .EMPTY_OUT(c_eo), .ORDER_FULL(c_full), .ORDER_CNT(c_cnt), .ORDER_ERR(c_err));
    acc_order_ctrl #(.NCH(2), .DEPTH(4), .MODE(0)) u_d (
        .S_CLK(clk), .S_RESET_N(rst_n), .WREN(d_wr), .RDEN(d_rd), .FIFO_EMPTY_IN(d_fe),
        .EMPTY_OUT(d_eo), .ORDER_FULL(d_full), .ORDER_CNT(d_cnt), .ORDER_ERR(d_err));

    // Reference model: arrival queue of channel numbers, RR grant, sticky error flags.
    int         mq[$];
    int         mg;
    logic [1:0] merr;

    function automatic logic [1:0] exp_err();
        return ERR_EN ? merr : 2'b00;
    endfunction

    function automatic logic [7:0] m1_eo(input int nch, input logic [7:0] fe);
        logic [7:0] e;
        e = 8'd0;
        for (int i = 0; i < nch; i++) e[i] = 1'b1;
        if (mq.size() != 0) e[mq[0]] = fe[mq[0]];
        return e;
    endfunction

    function automatic logic [2:0] m2_eo(input logic [2:0] fe);
        logic [2:0] e;
        e = 3'b111;
        e[mg] = fe[mg];
        return e;
    endfunction

    task automatic m1_step(input int nch, input int depth, input logic [7:0] wr, input logic [7:0] rd);
        int h;
        if (rd != 8'd0) begin
            if (mq.size() == 0) merr[1] = 1'b1;
            else begin
                h = mq[0];
                if ((rd & ~(8'd1 << h)) != 8'd0) merr[1] = 1'b1;
                if (rd[h]) void'(mq.pop_front());
            end
        end
        for (int i = 0; i < nch; i++) begin
            if (wr[i]) begin
                if (mq.size() < depth) mq.push_back(i);
                else merr[0] = 1'b1;
            end
        end
    endtask

    task automatic m2_step(input logic [2:0] fe, input logic [2:0] rd);
        if ((rd & ~(3'd1 << mg)) != 3'd0) merr[1] = 1'b1;
        if (rd[mg] || fe[mg]) mg = (mg + 1) % 3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_wr = '0; a_rd = '0; a_fe = '0;
        b_wr = '0; b_rd = '0; b_fe = '0;
        c_wr = '0; c_rd = '0; c_fe = '0;
        d_wr = '0; d_rd = '0; d_fe = '0;
        mq.delete();
        merr = 2'b00;
        mg = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_wr = '0; a_rd = '0; a_fe = 2'b00;
        b_wr = '0; b_rd = '0; b_fe = 4'b0000;
        c_wr = '0; c_rd = '0; c_fe = 3'b111;
        d_wr = '0; d_rd = '0; d_fe = 2'b10;
        #23;
        n_cmp++; if (a_eo !== 2'b11) begin n_fail++; $display("FAIL rst_a_eo: got %b expected 11", a_eo); end
        n_cmp++; if (b_eo !== 4'hf) begin n_fail++; $display("FAIL rst_b_eo: got %b expected 1111", b_eo); end
        n_cmp++; if (c_eo !== 3'b111) begin n_fail++; $display("FAIL rst_c_eo: got %b expected 111", c_eo); end
        n_cmp++; if (d_eo !== 2'b10) begin n_fail++; $display("FAIL rst_d_eo: got %b expected 10", d_eo); end
        n_cmp++; if ({a_cnt, b_cnt, c_cnt, d_cnt} !== 15'd0) begin n_fail++; $display("FAIL rst_cnt: got %h %h %h %h expected 0", a_cnt, b_cnt, c_cnt, d_cnt); end
        n_cmp++; if ({a_full, b_full, c_full, d_full} !== 4'd0) begin n_fail++; $display("FAIL rst_full: got %b%b%b%b expected 0000", a_full, b_full, c_full, d_full); end
        n_cmp++; if ({a_err, b_err, c_err, d_err} !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %b %b %b %b expected 0", a_err, b_err, c_err, d_err); end
        do_reset();
    endtask

    task automatic test_arrival_order();
        logic [1:0] wseq [7] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        int grants[$];
        do_reset();
        for (int c = 0; c < 7; c++) begin
            a_wr = wseq[c];
            a_rd = (mq.size() != 0) ? 2'(1 << mq[0]) : 2'b00;
            @(negedge clk);
            n_cmp++; if ({6'd0, a_eo} !== m1_eo(2, {6'd0, a_fe})) begin n_fail++; $display("FAIL arr_eo c%0d: got %b expected %b", c, a_eo, m1_eo(2, {6'd0, a_fe})); end
            n_cmp++; if (a_cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL arr_cnt c%0d: got %0d expected %0d", c, a_cnt, mq.size()); end
            if (a_eo == 2'b10) grants.push_back(0);
            else if (a_eo == 2'b01) grants.push_back(1);
            @(posedge clk);
            m1_step(2, 8, {6'd0, a_wr}, {6'd0, a_rd});
            #1;
        end
        a_wr = '0; a_rd = '0;
        n_cmp++;
        if (grants.size() != 3 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0) begin
            n_fail++; $display("FAIL arr_grant_seq: got %p expected '{0,1,0}", grants);
        end
    endtask

    task automatic test_multi_push();
        logic [3:0] wseq [5] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        int heads[$];
        do_reset();
        for (int c = 0; c < 5; c++) begin
            b_wr = wseq[c];
            b_rd = (mq.size() != 0) ? 4'(1 << mq[0]) : 4'b0000;
            @(negedge clk);
            n_cmp++; if ({4'd0, b_eo} !== m1_eo(4, {4'd0, b_fe})) begin n_fail++; $display("FAIL mp_eo c%0d: got %b expected %b", c, b_eo, m1_eo(4, {4'd0, b_fe})); end
            if (c == 1) begin
                n_cmp++; if (b_cnt !== 4'd3) begin n_fail++; $display("FAIL mp_cnt3: got %0d expected 3", b_cnt); end
            end
            for (int i = 0; i < 4; i++) if (b_eo == ~(4'd1 << i)) heads.push_back(i);
            @(posedge clk);
            m1_step(4, 8, {4'd0, b_wr}, {4'd0, b_rd});
            #1;
        end
        b_wr = '0; b_rd = '0;
        @(negedge clk);
        n_cmp++; if (heads.size() != 3 || heads[0] != 0 || heads[1] != 1 || heads[2] != 3) begin n_fail++; $display("FAIL mp_order: got %p expected '{0,1,3}", heads); end
        n_cmp++; if (b_cnt !== 4'd0 || b_eo !== 4'hf) begin n_fail++; $display("FAIL mp_drained: got cnt %0d eo %b expected 0 1111", b_cnt, b_eo); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            a_wr = (c < 9) ? 2'b01 : 2'b00;
            a_rd = 2'b00;
            @(negedge clk);
            n_cmp++; if (a_cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL ovf_cnt c%0d: got %0d expected %0d", c, a_cnt, mq.size()); end
            n_cmp++; if (a_full !== (mq.size() > 6)) begin n_fail++; $display("FAIL ovf_full c%0d: got %b expected %b", c, a_full, mq.size() > 6); end
            n_cmp++; if (a_err !== exp_err()) begin n_fail++; $display("FAIL ovf_err c%0d: got %b expected %b", c, a_err, exp_err()); end
            @(posedge clk);
            m1_step(2, 8, {6'd0, a_wr}, {6'd0, a_rd});
            #1;
        end
        a_wr = '0;
        @(negedge clk);
        n_cmp++; if (a_cnt !== 4'd8 || a_full !== 1'b1) begin n_fail++; $display("FAIL ovf_final: got cnt %0d full %b expected 8 1", a_cnt, a_full); end
        n_cmp++; if (a_err !== (ERR_EN ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", a_err, ERR_EN ? 2'b01 : 2'b00); end
        @(posedge clk); #1;
    endtask

    task automatic test_misorder();
        logic [1:0] wseq [6] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] rseq [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01};
        do_reset();
        a_fe = 2'b00;
        for (int c = 0; c < 6; c++) begin
            a_wr = wseq[c];
            a_rd = rseq[c];
            @(negedge clk);
            n_cmp++; if ({6'd0, a_eo} !== m1_eo(2, {6'd0, a_fe})) begin n_fail++; $display("FAIL mis_eo c%0d: got %b expected %b", c, a_eo, m1_eo(2, {6'd0, a_fe})); end
            n_cmp++; if (a_err !== exp_err()) begin n_fail++; $display("FAIL mis_err c%0d: got %b expected %b", c, a_err, exp_err()); end
            if (c == 2) begin
                n_cmp++; if (a_cnt !== 4'd1 || a_err[1] !== ERR_EN) begin n_fail++; $display("FAIL mis_hold: got cnt %0d err %b expected 1 and err1=%b", a_cnt, a_err, ERR_EN); end
            end
            @(posedge clk);
            m1_step(2, 8, {6'd0, a_wr}, {6'd0, a_rd});
            #1;
        end
        a_wr = '0; a_rd = '0;
    endtask

    task automatic test_random_m1();
        int r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            b_fe = 4'($urandom);
            b_wr = (c < 200 || $urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            r = $urandom_range(0, 9);
            if (mq.size() != 0 && !b_fe[mq[0]] && r < 7) b_rd = 4'(1 << mq[0]);
            else if (r == 9) b_rd = 4'(1 << $urandom_range(0, 3));
            else b_rd = 4'b0000;
            @(negedge clk);
            n_cmp++; if ({4'd0, b_eo} !== m1_eo(4, {4'd0, b_fe})) begin n_fail++; $display("FAIL rnd_eo c%0d: got %b expected %b", c, b_eo, m1_eo(4, {4'd0, b_fe})); end
            n_cmp++; if (b_cnt !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, b_cnt, mq.size()); end
            n_cmp++; if (b_full !== (mq.size() > 4)) begin n_fail++; $display("FAIL rnd_full c%0d: got %b expected %b", c, b_full, mq.size() > 4); end
            n_cmp++; if (b_err !== exp_err()) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected %b", c, b_err, exp_err()); end
            @(posedge clk);
            m1_step(4, 8, {4'd0, b_wr}, {4'd0, b_rd});
            #1;
        end
        b_wr = '0; b_rd = '0; b_fe = '0;
    endtask

    task automatic test_round_robin();
        int pops[$];
        int r;
        do_reset();
        c_fe = 3'b010;
        for (int c = 0; c < 8; c++) begin
            #1;
            c_rd = ~c_eo;
            @(negedge clk);
            n_cmp++; if (c_eo !== m2_eo(c_fe)) begin n_fail++; $display("FAIL rr_eo c%0d: got %b expected %b", c, c_eo, m2_eo(c_fe)); end
            for (int i = 0; i < 3; i++) if (c_rd[i]) pops.push_back(i);
            @(posedge clk);
            m2_step(c_fe, c_rd);
            #1;
        end
        n_cmp++; if (pops.size() < 4 || pops[0] != 0 || pops[1] != 2 || pops[2] != 0 || pops[3] != 2) begin n_fail++; $display("FAIL rr_seq: got %p expected 0,2,0,2", pops); end
        for (int c = 0; c < 200; c++) begin
            c_fe = 3'($urandom);
            c_wr = 3'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) c_rd = 3'(1 << mg);
            else if (r == 9 && !c_fe[mg]) c_rd = 3'(1 << ((mg + 1 + $urandom_range(0, 1)) % 3));
            else c_rd = 3'b000;
            @(negedge clk);
            n_cmp++; if (c_eo !== m2_eo(c_fe)) begin n_fail++; $display("FAIL rr_rnd_eo c%0d: got %b expected %b", c, c_eo, m2_eo(c_fe)); end
            n_cmp++; if (c_cnt !== 4'd0 || c_full !== 1'b0) begin n_fail++; $display("FAIL rr_rnd_q c%0d: got cnt %0d full %b expected 0 0", c, c_cnt, c_full); end
            n_cmp++; if (c_err !== exp_err()) begin n_fail++; $display("FAIL rr_rnd_err c%0d: got %b expected %b", c, c_err, exp_err()); end
            @(posedge clk);
            m2_step(c_fe, c_rd);
            #1;
        end
        c_wr = '0; c_rd = '0; c_fe = '0;
    endtask

    task automatic test_reset_midburst();
        do_reset();
        b_fe = 4'b0000;
        b_wr = 4'b1111;
        @(posedge clk); #1;
        b_wr = 4'b0001;
        @(posedge clk); #1;
        b_wr = 4'b0000;
        @(negedge clk);
        n_cmp++; if (b_cnt !== 4'd5 || b_full !== 1'b1) begin n_fail++; $display("FAIL mid_before: got cnt %0d full %b expected 5 1", b_cnt, b_full); end
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete(); merr = 2'b00;
        n_cmp++; if (b_cnt !== 4'd0 || b_full !== 1'b0 || b_err !== 2'b00) begin n_fail++; $display("FAIL mid_rst_regs: got cnt %0d full %b err %b expected 0 0 00", b_cnt, b_full, b_err); end
        n_cmp++; if (b_eo !== 4'hf) begin n_fail++; $display("FAIL mid_rst_eo: got %b expected 1111", b_eo); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        b_wr = 4'b0100;
        @(negedge clk);
        n_cmp++; if (b_eo !== 4'hf) begin n_fail++; $display("FAIL mid_same_cycle: got %b expected 1111", b_eo); end
        @(posedge clk); #1;
        b_wr = 4'b0000;
        @(negedge clk);
        n_cmp++; if (b_eo !== 4'b1011 || b_cnt !== 4'd1) begin n_fail++; $display("FAIL mid_next_grant: got eo %b cnt %0d expected 1011 1", b_eo, b_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            d_fe = 2'($urandom);
            d_wr = 2'($urandom);
            d_rd = 2'($urandom);
            @(negedge clk);
            n_cmp++; if (d_eo !== d_fe) begin n_fail++; $display("FAIL pt_eo c%0d: got %b expected %b", c, d_eo, d_fe); end
            n_cmp++; if (d_cnt !== 3'd0 || d_full !== 1'b0 || d_err !== 2'b00) begin n_fail++; $display("FAIL pt_q c%0d: got cnt %0d full %b err %b expected 0 0 00", c, d_cnt, d_full, d_err); end
            @(posedge clk); #1;
        end
        d_wr = '0; d_rd = '0; d_fe = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arrival_order();
        test_multi_push();
        test_overflow();
        test_misorder();
        test_random_m1();
        test_round_robin();
        test_reset_midburst();
        test_passthrough();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
